// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI target register block.
package spi_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 8;
  localparam int RNW_BIT = 7;
  localparam int MS_BIT  = 6;
  localparam int SIM_BIT = 0;

  localparam logic [ADDR_W-1:0] CTRL_REG4_ADDR = 6'h23;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input plus rise/fall pulses
// on the synchronized level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Left unreset so a reset never fabricates an edge from a held input.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-3 target with a 64x8 register file and write-notify strobe.
// Optional 3-wire support (SIM bit in register 0x23) via macro SPI3WIRE_EN.
module spi_target_regs
  import spi_pkg::*;
#(
  parameter logic [DATA_W-1:0] WHOAMI      = 8'h33,
  parameter logic [ADDR_W-1:0] WHOAMI_ADDR = 6'h0F,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csn,
  input  logic              sck,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic sck_s, sck_rise, sck_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .din  (sck),
    .dout (sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d, sdi_sync_q, sdi_sync_d;
  logic                   csn_prev_q, csn_prev_d;
  logic                   csn_s, sdi_s, csn_fall, csn_rise;

  always_comb begin
    csn_sync_d = {csn_sync_q[SYNC_STAGES-2:0], csn};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    csn_prev_d = csn_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    csn_sync_q <= csn_sync_d;
    sdi_sync_q <= sdi_sync_d;
    csn_prev_q <= csn_prev_d;
  end

  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign csn_fall = ~csn_s & csn_prev_q;
  assign csn_rise = csn_s & ~csn_prev_q;

  spi_state_t        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic              rnw_q, rnw_d, ms_q, ms_d, load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] tx_q, tx_d, wr_data_q, wr_data_d, rx_byte, rd_val;
  logic              sdo_q, sdo_d, sdo_oe_q, sdo_oe_d, wr_strobe_q, wr_strobe_d;
  logic              sdi_ignore;
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [DATA_W-1:0] regs_d [2**ADDR_W];

  assign rx_byte = {shift_q, sdi_s};
  assign rd_val  = (addr_q == WHOAMI_ADDR) ? WHOAMI : regs_q[addr_q];

`ifdef SPI3WIRE_EN
  logic sim_q, sim_d;
  // SIM is captured at frame start so it never changes mid-frame.
  assign sdi_ignore = sim_q & rnw_q;
  assign sdo        = sim_q ? (sdo_q & sdo_oe_q) : sdo_q;
`else
  assign sdi_ignore = 1'b0;
  assign sdo        = sdo_q;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rnw_d       = rnw_q;
    ms_d        = ms_q;
    addr_d      = addr_q;
    load_d      = load_q;
    tx_d        = tx_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
`ifdef SPI3WIRE_EN
    sim_d       = sim_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
          sdo_oe_d  = 1'b0;
          load_d    = 1'b0;
`ifdef SPI3WIRE_EN
          sim_d     = regs_q[CTRL_REG4_ADDR][SIM_BIT];
`endif
        end
      end
      CMD: begin
        if (sck_rise) begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rnw_d   = rx_byte[RNW_BIT];
            ms_d    = rx_byte[MS_BIT];
            addr_d  = rx_byte[ADDR_W-1:0];
            load_d  = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (sck_rise) begin
          if (!sdi_ignore) shift_d = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rnw_q && addr_q != WHOAMI_ADDR) begin
              regs_d[addr_q] = rx_byte;
              wr_strobe_d    = 1'b1;
              wr_addr_d      = addr_q;
              wr_data_d      = rx_byte;
            end
            if (ms_q) addr_d = addr_q + 6'd1;
            load_d = rnw_q;
          end
        end
        // The first fall of each read byte snapshots the register; later falls shift.
        if (sck_fall && rnw_q) begin
          if (load_q) begin
            sdo_d    = rd_val[7];
            tx_d     = {rd_val[6:0], 1'b0};
            sdo_oe_d = 1'b1;
            load_d   = 1'b0;
          end else begin
            sdo_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Applied after the byte logic so an 8th rise seen with csn rise still commits.
    if (state_q != IDLE && csn_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      sdo_d     = 1'b0;
      sdo_oe_d  = 1'b0;
      load_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      rnw_q       <= 1'b0;
      ms_q        <= 1'b0;
      addr_q      <= '0;
      load_q      <= 1'b0;
      tx_q        <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      regs_q      <= '{default: '0};
`ifdef SPI3WIRE_EN
      sim_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rnw_q       <= rnw_d;
      ms_q        <= ms_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      tx_q        <= tx_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
`ifdef SPI3WIRE_EN
      sim_q       <= sim_d;
`endif
    end
  end

  assign sdo_oe    = sdo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed self-checking bench for spi_target_regs acting as an SPI mode-3 master.
module tb_spi_target_regs;

  localparam int HP = 6;

  logic       clk = 1'b0;
  logic       reset, csn, sck, sdi;
  logic       sdo, sdo_oe, wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int vectors    = 0;
  int miscompares = 0;

  logic [5:0] st_addr [$];
  logic [7:0] st_data [$];

  spi_target_regs dut (
    .clk       (clk),
    .reset     (reset),
    .csn       (csn),
    .sck       (sck),
    .sdi       (sdi),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      st_addr.push_back(wr_addr);
      st_data.push_back(wr_data);
    end
  end

  task automatic csn_start();
    @(negedge clk);
    csn = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic csn_end();
    @(negedge clk);
    csn = 1'b1;
    repeat (2*HP) @(negedge clk);
  endtask

  // Master drives sdi on sck fall and samples sdo just before sck rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_and, output logic oe_or);
    rx = 8'h00; oe_and = 1'b1; oe_or = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sck = 1'b0;
      sdi = tx[7-i];
      repeat (HP) @(negedge clk);
      rx = {rx[6:0], sdo};
      oe_and = oe_and & sdo_oe;
      oe_or  = oe_or | sdo_oe;
      sck = 1'b1;
      repeat (HP-1) @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic a, o;
    spi_bits(tx, 8, rx, a, o);
  endtask

  task automatic write1(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    csn_start();
    spi_byte(cmd, rx);
    spi_byte(data, rx);
    csn_end();
  endtask

  task automatic read1(input logic [7:0] cmd, input logic [7:0] dummy, output logic [7:0] rx);
    logic [7:0] r;
    csn_start();
    spi_byte(cmd, r);
    spi_byte(dummy, rx);
    csn_end();
  endtask

  task automatic test_reset();
    vectors++; if (sdo !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sdo: got %b expected 0", sdo); end
    vectors++; if (sdo_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sdo_oe: got %b expected 0", sdo_oe); end
    vectors++; if (wr_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    vectors++; if (wr_addr !== 6'h00) begin miscompares++; $display("[TB] FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    vectors++; if (wr_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_wr_data: got %h expected 00", wr_data); end
  endtask

  task automatic test_whoami();
    logic [7:0] rx;
    logic a, o;
    int base = st_addr.size();
    csn_start();
    spi_bits(8'h8F, 8, rx, a, o);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("[TB] FAIL whoami_cmd_oe: got %b expected 0", o); end
    spi_bits(8'h00, 8, rx, a, o);
    vectors++; if (rx !== 8'h33) begin miscompares++; $display("[TB] FAIL whoami_data: got %h expected 33", rx); end
    vectors++; if (a !== 1'b1) begin miscompares++; $display("[TB] FAIL whoami_data_oe: got %b expected 1", a); end
    csn_end();
    vectors++; if (sdo_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL whoami_oe_after: got %b expected 0", sdo_oe); end
    vectors++; if (st_addr.size() - base !== 0) begin miscompares++; $display("[TB] FAIL whoami_strobes: got %0d expected 0", st_addr.size() - base); end
  endtask

  task automatic test_write_read();
    logic [7:0] rx;
    int base = st_addr.size();
    write1(8'h20, 8'hA5);
    vectors++; if (st_addr.size() - base !== 1) begin miscompares++; $display("[TB] FAIL wr_strobe_count: got %0d expected 1", st_addr.size() - base); end
    else begin
      vectors++; if (st_addr[base] !== 6'h20) begin miscompares++; $display("[TB] FAIL wr_addr: got %h expected 20", st_addr[base]); end
      vectors++; if (st_data[base] !== 8'hA5) begin miscompares++; $display("[TB] FAIL wr_data: got %h expected a5", st_data[base]); end
    end
    read1(8'hA0, 8'h00, rx);
    vectors++; if (rx !== 8'hA5) begin miscompares++; $display("[TB] FAIL readback_20: got %h expected a5", rx); end
  endtask

  task automatic test_burst();
    logic [7:0] rx;
    logic [5:0] exp_a [3] = '{6'h3E, 6'h3F, 6'h00};
    logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    int base = st_addr.size();
    csn_start();
    spi_byte(8'h7E, rx);
    for (int i = 0; i < 3; i++) spi_byte(exp_d[i], rx);
    csn_end();
    vectors++; if (st_addr.size() - base !== 3) begin miscompares++; $display("[TB] FAIL burst_strobes: got %0d expected 3", st_addr.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        vectors++; if (st_addr[base+i] !== exp_a[i] || st_data[base+i] !== exp_d[i]) begin
          miscompares++; $display("[TB] FAIL burst_strobe%0d: got %h/%h expected %h/%h", i, st_addr[base+i], st_data[base+i], exp_a[i], exp_d[i]);
        end
      end
    end
    csn_start();
    spi_byte(8'hFE, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, rx);
      vectors++; if (rx !== exp_d[i]) begin miscompares++; $display("[TB] FAIL burst_read%0d: got %h expected %h", i, rx, exp_d[i]); end
    end
    csn_end();
  endtask

  task automatic test_no_increment();
    logic [7:0] rx;
    csn_start();
    spi_byte(8'hA0, rx);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx);
      vectors++; if (rx !== 8'hA5) begin miscompares++; $display("[TB] FAIL hold_addr_read%0d: got %h expected a5", i, rx); end
    end
    csn_end();
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic a, o;
    int base;
    write1(8'h10, 8'h5A);
    base = st_addr.size();
    csn_start();
    spi_byte(8'h10, rx);
    spi_bits(8'hFF, 5, rx, a, o);
    csn_end();
    vectors++; if (st_addr.size() - base !== 0) begin miscompares++; $display("[TB] FAIL abort_strobes: got %0d expected 0", st_addr.size() - base); end
    read1(8'h90, 8'h00, rx);
    vectors++; if (rx !== 8'h5A) begin miscompares++; $display("[TB] FAIL abort_reg10: got %h expected 5a", rx); end
    base = st_addr.size();
    write1(8'h0F, 8'h55);
    vectors++; if (st_addr.size() - base !== 0) begin miscompares++; $display("[TB] FAIL whoami_write_strobes: got %0d expected 0", st_addr.size() - base); end
    read1(8'h8F, 8'h00, rx);
    vectors++; if (rx !== 8'h33) begin miscompares++; $display("[TB] FAIL whoami_protect: got %h expected 33", rx); end
  endtask

  task automatic test_ctrl_reg();
    logic [7:0] rx;
    write1(8'h23, 8'h01);
    read1(8'hA3, 8'h00, rx);
    vectors++; if (rx !== 8'h01) begin miscompares++; $display("[TB] FAIL ctrl_reg_rd: got %h expected 01", rx); end
    read1(8'h8F, 8'hAA, rx);
    vectors++; if (rx !== 8'h33) begin miscompares++; $display("[TB] FAIL sim_whoami: got %h expected 33", rx); end
    write1(8'h23, 8'h00);
    read1(8'hA3, 8'hFF, rx);
    vectors++; if (rx !== 8'h00) begin miscompares++; $display("[TB] FAIL ctrl_reg_clear: got %h expected 00", rx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx;
    logic a, o;
    int base = st_addr.size();
    csn_start();
    spi_byte(8'hA0, rx);
    spi_bits(8'h00, 3, rx, a, o);
    vectors++; if (rx[2:0] !== 3'b101 || sdo_oe !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pre_reset: got bits %b oe %b expected 101 oe 1", rx[2:0], sdo_oe);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (sdo !== 1'b0 || sdo_oe !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_reset_out: got sdo %b oe %b expected 0 0", sdo, sdo_oe);
    end
    reset = 1'b0;
    spi_bits(8'hFF, 5, rx, a, o);
    spi_bits(8'hFF, 8, rx, a, o);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("[TB] FAIL ignored_frame_oe: got %b expected 0", o); end
    csn_end();
    vectors++; if (st_addr.size() - base !== 0) begin miscompares++; $display("[TB] FAIL ignored_frame_strobes: got %0d expected 0", st_addr.size() - base); end
    read1(8'hA0, 8'h00, rx);
    vectors++; if (rx !== 8'h00) begin miscompares++; $display("[TB] FAIL regs_cleared: got %h expected 00", rx); end
    read1(8'h8F, 8'h00, rx);
    vectors++; if (rx !== 8'h33) begin miscompares++; $display("[TB] FAIL post_reset_whoami: got %h expected 33", rx); end
  endtask

  initial begin
    reset = 1'b1;
    csn   = 1'b1;
    sck   = 1'b1;
    sdi   = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_whoami();
    test_write_read();
    test_burst();
    test_no_increment();
    test_abort();
    test_ctrl_reg();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
